// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg
// Shared definitions for the PLL reset sequencer:
//   - state_t     : sequencer FSM state encoding
//   - cnt_width() : width of the shared cycle counter
//   - DEF_*       : default parameter values
package pll_reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    SDRAM_INIT = 3'd2,
    CORE_DLY   = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_SDRAM_INIT_TIMEOUT = 65535;
  localparam int DEF_CORE_DELAY_CYCLES  = 16;

  // One counter serves all three timed states, so it is sized for the
  // largest limit, with one spare bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit
// N-stage flop synchroniser for a single asynchronous bit.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronised output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the PLL lock and releases resets in order: SDRAM controller
// first, then the core once the SDRAM controller reports init complete.
// Any loss of lock re-runs the whole sequence from WAIT_LOCK.
// Ports:
//   clk             : PLL clkout, the only clock
//   rst             : synchronous active-high reset
//   pll_lock        : raw PLL lock, asynchronous to clk
//   sdram_init_done : level, high once the SDRAM controller is initialised
//   sdram_rst       : active-high reset to the SDRAM controller
//   core_rst        : active-high reset to core and tester
//   ready           : high only in RUN
//   fault           : SDRAM init timed out (held until the next init attempt)
//   lock_loss_count : saturating count of synchronised-lock falling edges
//   state_dbg       : current FSM state (encoding of state_t)
// All outputs are registered.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int SDRAM_INIT_TIMEOUT = DEF_SDRAM_INIT_TIMEOUT,
  parameter int CORE_DELAY_CYCLES  = DEF_CORE_DELAY_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       sdram_init_done,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_dbg
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, SDRAM_INIT_TIMEOUT,
                                CORE_DELAY_CYCLES);

  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(SDRAM_INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] CORE_LAST    = CW'(CORE_DELAY_CYCLES - 1);

  logic          lock_s;
  logic          lock_s_q;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          sdram_rst_n, core_rst_n, ready_n, fault_n;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // ---------------------------------------------------------------------
  // Lock-loss counter: counts 1->0 transitions of the synchronised lock,
  // regardless of FSM state, and sticks at 255.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s_q        <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      lock_s_q <= lock_s;
      if (lock_s_q && !lock_s && (lock_loss_count != 8'hFF)) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM state and registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      sdram_rst <= 1'b1;
      core_rst  <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      sdram_rst <= sdram_rst_n;
      core_rst  <= core_rst_n;
      ready     <= ready_n;
      fault     <= fault_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state / next-output logic. Lock loss is tested first in every
  // state, giving it priority over init-done and the timeout. fault is
  // deliberately left untouched on lock loss; it clears only when
  // SDRAM_INIT is entered again.
  // ---------------------------------------------------------------------
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    sdram_rst_n = sdram_rst;
    core_rst_n  = core_rst;
    ready_n     = ready;
    fault_n     = fault;

    if ((state_q != WAIT_LOCK) && !lock_s) begin
      state_n     = WAIT_LOCK;
      cnt_n       = '0;
      sdram_rst_n = 1'b1;
      core_rst_n  = 1'b1;
      ready_n     = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          sdram_rst_n = 1'b1;
          core_rst_n  = 1'b1;
          ready_n     = 1'b0;
          if (lock_s) begin
            state_n = STABLE;
            cnt_n   = '0;
          end
        end

        STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_n     = SDRAM_INIT;
            cnt_n       = '0;
            sdram_rst_n = 1'b0;
            fault_n     = 1'b0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end

        SDRAM_INIT: begin
          // cnt_q is 0 only in the first cycle after entry; done is not
          // trusted there because the controller has only just left reset
          // and may still present a stale level.
          if ((cnt_q != '0) && sdram_init_done) begin
            state_n = CORE_DLY;
            cnt_n   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_n     = FAULT;
            cnt_n       = '0;
            sdram_rst_n = 1'b1;
            core_rst_n  = 1'b1;
            ready_n     = 1'b0;
            fault_n     = 1'b1;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end

        CORE_DLY: begin
          if (cnt_q == CORE_LAST) begin
            state_n    = RUN;
            cnt_n      = '0;
            core_rst_n = 1'b0;
            ready_n    = 1'b1;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end

        RUN: begin
          // Hold until lock is lost (handled above).
        end

        FAULT: begin
          sdram_rst_n = 1'b1;
          core_rst_n  = 1'b1;
          ready_n     = 1'b0;
          fault_n     = 1'b1;
        end

        default: begin
          state_n     = WAIT_LOCK;
          cnt_n       = '0;
          sdram_rst_n = 1'b1;
          core_rst_n  = 1'b1;
          ready_n     = 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2,
// LOCK_STABLE_CYCLES=8, SDRAM_INIT_TIMEOUT=20, CORE_DELAY_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are checked at that
// same point, i.e. well away from the next active edge.
module tb_pll_reset_sequencer;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_STABLE = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_CORE   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       sdram_init_done;
  logic       sdram_rst;
  logic       core_rst;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_count;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .SDRAM_INIT_TIMEOUT (20),
    .CORE_DELAY_CYCLES  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_lock        (pll_lock),
    .sdram_init_done (sdram_init_done),
    .sdram_rst       (sdram_rst),
    .core_rst        (core_rst),
    .ready           (ready),
    .fault           (fault),
    .lock_loss_count (lock_loss_count),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_sdram,
                           input logic e_core, input logic e_ready,
                           input logic e_fault, input logic [7:0] e_cnt,
                           input logic [2:0] e_state);
    check({tag, ".sdram_rst"},       {7'd0, sdram_rst}, {7'd0, e_sdram});
    check({tag, ".core_rst"},        {7'd0, core_rst},  {7'd0, e_core});
    check({tag, ".ready"},           {7'd0, ready},     {7'd0, e_ready});
    check({tag, ".fault"},           {7'd0, fault},     {7'd0, e_fault});
    check({tag, ".lock_loss_count"}, lock_loss_count,   e_cnt);
    check({tag, ".state"},           {5'd0, state_dbg}, {5'd0, e_state});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  // Each record: drive lock/done, advance n edges, then compare outputs.
  typedef struct {
    logic       lock;
    logic       done;
    int         n;
    logic       e_sdram;
    logic       e_core;
    logic       e_ready;
    logic       e_fault;
    logic [7:0] e_cnt;
    logic [2:0] e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lk, input logic dn, input int n,
                     input logic es, input logic ec, input logic er,
                     input logic ef, input logic [7:0] cnt,
                     input logic [2:0] st);
    vec_t v;
    v.lock = lk; v.done = dn; v.n = n;
    v.e_sdram = es; v.e_core = ec; v.e_ready = er; v.e_fault = ef;
    v.e_cnt = cnt; v.e_state = st;
    vecs.push_back(v);
  endtask

  // watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    pll_lock        = 1'b0;
    sdram_init_done = 1'b0;

    // Normal bring-up (lock at edge 0, done at edge 15), lock loss in RUN,
    // then relock with done already high (early-done case).
    //   lock done n  sdram core rdy flt cnt state
    add(1, 0, 1,  1, 1, 0, 0, 8'd0, S_WAIT);    // edge 0
    add(1, 0, 1,  1, 1, 0, 0, 8'd0, S_WAIT);    // edge 1: lock_s now high
    add(1, 0, 1,  1, 1, 0, 0, 8'd0, S_STABLE);  // edge 2
    add(1, 0, 7,  1, 1, 0, 0, 8'd0, S_STABLE);  // edge 9
    add(1, 0, 1,  0, 1, 0, 0, 8'd0, S_INIT);    // edge 10: sdram_rst low
    add(1, 0, 4,  0, 1, 0, 0, 8'd0, S_INIT);    // edge 14
    add(1, 1, 1,  0, 1, 0, 0, 8'd0, S_CORE);    // edge 15: done sampled
    add(1, 1, 3,  0, 1, 0, 0, 8'd0, S_CORE);    // edge 18
    add(1, 1, 1,  0, 0, 1, 0, 8'd0, S_RUN);     // edge 19: core released
    add(1, 1, 3,  0, 0, 1, 0, 8'd0, S_RUN);
    add(0, 1, 1,  0, 0, 1, 0, 8'd0, S_RUN);     // edge T: lock falls
    add(0, 1, 1,  0, 0, 1, 0, 8'd0, S_RUN);     // edge T+1
    add(0, 1, 1,  1, 1, 0, 0, 8'd1, S_WAIT);    // edge T+2: resets back
    add(0, 1, 3,  1, 1, 0, 0, 8'd1, S_WAIT);
    add(1, 1, 2,  1, 1, 0, 0, 8'd1, S_WAIT);    // relock edges 0,1
    add(1, 1, 1,  1, 1, 0, 0, 8'd1, S_STABLE);  // edge 2
    add(1, 1, 7,  1, 1, 0, 0, 8'd1, S_STABLE);  // edge 9
    add(1, 1, 1,  0, 1, 0, 0, 8'd1, S_INIT);    // edge 10
    add(1, 1, 1,  0, 1, 0, 0, 8'd1, S_INIT);    // edge 11: done ignored
    add(1, 1, 1,  0, 1, 0, 0, 8'd1, S_CORE);    // edge 12
    add(1, 1, 3,  0, 1, 0, 0, 8'd1, S_CORE);    // edge 15
    add(1, 1, 1,  0, 0, 1, 0, 8'd1, S_RUN);     // edge 16

    do_reset();
    check_all("reset", 1, 1, 0, 0, 8'd0, S_WAIT);

    for (int i = 0; i < vecs.size(); i++) begin
      pll_lock        = vecs[i].lock;
      sdram_init_done = vecs[i].done;
      step(vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i].e_sdram, vecs[i].e_core,
                vecs[i].e_ready, vecs[i].e_fault, vecs[i].e_cnt,
                vecs[i].e_state);
    end

    // ---- glitchy lock: high 5, low 1, then high ----
    pll_lock = 1'b0; sdram_init_done = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    step(5);                       // edges 0..4
    pll_lock = 1'b0;
    step(1);                       // edge 5
    pll_lock = 1'b1;
    for (int e = 6; e <= 15; e++) begin
      step(1);
      check($sformatf("glitch.sdram_rst_e%0d", e), {7'd0, sdram_rst}, 8'd1);
      if (e == 7) check("glitch.state_e7", {5'd0, state_dbg}, {5'd0, S_WAIT});
    end
    step(1);                       // edge 16
    check("glitch.sdram_rst_e16", {7'd0, sdram_rst}, 8'd0);
    check("glitch.count", lock_loss_count, 8'd1);

    // ---- init timeout, then lock loss and re-init clears fault ----
    pll_lock = 1'b0; sdram_init_done = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    step(11);                      // edge 10
    check_all("tmo.e10", 0, 1, 0, 0, 8'd0, S_INIT);
    step(19);                      // edge 29
    check_all("tmo.e29", 0, 1, 0, 0, 8'd0, S_INIT);
    step(1);                       // edge 30
    check_all("tmo.e30", 1, 1, 0, 1, 8'd0, S_FAULT);
    pll_lock = 1'b0;
    step(3);                       // edges 31..33
    check_all("tmo.lost", 1, 1, 0, 1, 8'd1, S_WAIT);
    pll_lock = 1'b1;
    step(10);                      // new edges 0..9
    check_all("tmo.relock9", 1, 1, 0, 1, 8'd1, S_STABLE);
    step(1);                       // new edge 10
    check_all("tmo.reinit", 0, 1, 0, 0, 8'd1, S_INIT);

    // ---- rst asserted in CORE_DLY ----
    sdram_init_done = 1'b1;
    step(2);                       // first cycle ignored, then CORE_DLY
    check_all("rstcore.pre", 0, 1, 0, 0, 8'd1, S_CORE);
    rst = 1'b1;
    step(1);
    check_all("rstcore.post", 1, 1, 0, 0, 8'd0, S_WAIT);
    rst = 1'b0;

    // ---- loss counter counts each fall and saturates ----
    pll_lock = 1'b0; sdram_init_done = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      pll_lock = 1'b1; step(1);
      pll_lock = 1'b0; step(1);
    end
    step(3);
    check("sat.count10", lock_loss_count, 8'd10);
    for (int k = 0; k < 300; k++) begin
      pll_lock = 1'b1; step(1);
      pll_lock = 1'b0; step(1);
    end
    step(3);
    check("sat.count255", lock_loss_count, 8'd255);
    check_all("sat.outputs", 1, 1, 0, 0, 8'd255, S_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the PLL `lock` output and produces the ordered reset releases for the rest of the design. The SDRAM controller reset is released first; the core reset (Apple IIe core and tester) is released only after the SDRAM controller reports initialisation complete. The block synchronises and qualifies `lock`, times out a stalled SDRAM init, and re-sequences from scratch whenever lock is lost. It runs on the PLL `clkout` domain.

## Interface

Parameters:
- `SYNC_STAGES`, 2: number of synchroniser flops on `pll_lock`; must be ≥ 2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles the synchronised lock must stay high before SDRAM reset release; must be ≥ 1.
- `SDRAM_INIT_TIMEOUT`, 65535: maximum cycles spent waiting for `sdram_init_done`.
- `CORE_DELAY_CYCLES`, 16: cycles between init-done and core reset release; must be ≥ 1.

Ports:
- `clk` in 1: PLL `clkout`; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_lock` in 1: raw PLL lock, asynchronous to `clk`.
- `sdram_init_done` in 1: level from the SDRAM controller; high once its init is complete.
- `sdram_rst` out 1: active-high reset to the SDRAM controller.
- `core_rst` out 1: active-high reset to the core and tester logic.
- `ready` out 1: high only in RUN.
- `fault` out 1: SDRAM init timeout flag.
- `lock_loss_count` out 8: saturating count of synchronised-lock falling edges.

## Operation

- Reset values: `sdram_rst`=1, `core_rst`=1, `ready`=0, `fault`=0, `lock_loss_count`=0, state=WAIT_LOCK, all counters 0, synchroniser flops 0.
- `lock_s` is the output of the `SYNC_STAGES`-deep synchroniser.
- States:
  - WAIT_LOCK:
    - Both resets asserted.
    - On `lock_s`=1 go to STABLE and set cnt=0.
  - STABLE:
    - If `lock_s`=0, return to WAIT_LOCK.
    - Else, if cnt==`LOCK_STABLE_CYCLES`-1, go to SDRAM_INIT, register `sdram_rst`=0, clear cnt and `fault`.
    - Else cnt++.
  - SDRAM_INIT:
    - `sdram_init_done` is ignored in the first cycle in this state.
    - From the second cycle on, done=1 moves to CORE_DLY with cnt=0.
    - Otherwise cnt++.
    - If cnt reaches `SDRAM_INIT_TIMEOUT` without done, go to FAULT.
  - CORE_DLY:
    - When cnt==`CORE_DELAY_CYCLES`-1, go to RUN and register `core_rst`=0 and `ready`=1.
    - Otherwise cnt++.
  - RUN: hold until lock is lost.
  - FAULT:
    - `fault`=1, `sdram_rst`=1, `core_rst`=1.
    - Stays in FAULT until lock is lost or `rst`.
- Lock loss: `lock_s`=0 in STABLE, SDRAM_INIT, CORE_DLY, RUN or FAULT gives the following on the next edge:
  - state=WAIT_LOCK
  - `sdram_rst`=1, `core_rst`=1, `ready`=0
  - `fault` is retained until the next SDRAM_INIT entry.
- `lock_loss_count` increments on every 1→0 transition of `lock_s` and saturates at 255. It is cleared only by `rst`.
- Priority on the same edge: lock loss > init done > timeout.
- `rst` mid-sequence restores all reset values on the same edge, regardless of state.
- Counter width: $clog2 of the largest of the three cycle parameters, +1.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Edge 0 is the first edge sampling `pll_lock`=1.
  - `lock_s` is high after edge `SYNC_STAGES`-1.
  - STABLE is entered at edge `SYNC_STAGES`.
  - `sdram_rst` falls after edge `SYNC_STAGES`+`LOCK_STABLE_CYCLES`.
- If SDRAM_INIT is entered at edge E and done is first sampled high at edge D ≥ E+2:
  - `core_rst` falls and `ready` rises after edge D+`CORE_DELAY_CYCLES`.
- If done never arrives, `fault` rises after edge E+`SDRAM_INIT_TIMEOUT`. `sdram_rst` reasserts on that same edge.
- Response to lock loss: `SYNC_STAGES`+1 edges from raw `pll_lock` falling to both resets asserted.

## Structure

- Package `pll_reset_pkg`:
  - state enum (WAIT_LOCK, STABLE, SDRAM_INIT, CORE_DLY, RUN, FAULT)
  - counter-width function
  - default parameter constants.
- Sub-module `sync_bit`: N-stage flop synchroniser, with synchronous reset to 0.
- The sequencer FSM, shared counter and loss counter live in `pll_reset_sequencer`.

## Test plan

All scenarios use `SYNC_STAGES`=2, `LOCK_STABLE_CYCLES`=8, `SDRAM_INIT_TIMEOUT`=20, `CORE_DELAY_CYCLES`=4.

- Normal bring-up:
  - Stimulus: `pll_lock` rises at edge 0; done rises at edge 15.
  - Required: `sdram_rst` low after edge 10; `core_rst` low and `ready` high after edge 19; `fault`=0.
- Glitchy lock:
  - Stimulus: lock high for 5 cycles, low for 1, then high.
  - Required: `sdram_rst` never deasserts before 10 clean cycles; `lock_loss_count`=1.
- Init timeout:
  - Stimulus: done held low.
  - Required: `fault`=1 after edge 30; both resets high; `ready`=0.
  - Then drop and restore lock: `fault` clears when SDRAM_INIT is re-entered.
- Early done:
  - Stimulus: done already high on SDRAM_INIT entry.
  - Required: done is ignored in the first cycle; CORE_DLY is entered one cycle later.
- Lock loss in RUN:
  - Stimulus: `pll_lock` falls at edge T.
  - Required: `sdram_rst`/`core_rst`=1 and `ready`=0 after edge T+2; count increments; full re-sequence on relock.
- `rst` asserted in CORE_DLY: all outputs return to reset values on the next edge.
